// File: rtl/if_stage_pkg.sv
// Shared constants for the OpenMIPS fetch stage: reset/enable levels and the
// ctrl stall vector bit positions.
package if_stage_pkg;

  localparam logic RST_ENABLE   = 1'b1;
  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;
  localparam logic STOP         = 1'b1;

  localparam int STALL_PC    = 0;
  localparam int STALL_IF_ID = 1;
  localparam int STALL_ID_EX = 2;

endpackage

// File: rtl/if_stage_if_id.sv
// IF/ID pipeline register: carries the fetched instruction and its PC to decode,
// inserting a bubble when IF stalls but ID does not.
module if_stage_if_id
  import if_stage_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              stall_if,
  input  logic              stall_id,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic [INST_W-1:0] if_inst,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE || flush) begin
      id_pc   <= '0;
      id_inst <= '0;
    end else if (stall_if == STOP && stall_id != STOP) begin
      id_pc   <= '0;
      id_inst <= '0;
    end else if (stall_if != STOP) begin
      id_pc   <= if_pc;
      id_inst <= if_inst;
    end
  end

endmodule

// File: rtl/if_stage.sv
// OpenMIPS instruction-fetch stage: PC register, ROM chip enable and IF/ID
// register, honouring ctrl stall/flush and ID branch redirects.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32,
  parameter int          INST_W   = 32,
  parameter int          STALL_W  = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  new_pc,
  input  logic               branch_flag_i,
  input  logic [ADDR_W-1:0]  branch_target_address_i,
  input  logic [INST_W-1:0]  inst_i,
  output logic [ADDR_W-1:0]  pc,
  output logic               ce,
  output logic [ADDR_W-1:0]  id_pc,
  output logic [INST_W-1:0]  id_inst
);

  logic [INST_W-1:0]  fetched_inst;
  logic [STALL_W-1:0] stall_unused;

  // Stall bits above ID/EX belong to later stages.
  assign stall_unused = stall;

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      ce <= CHIP_DISABLE;
      pc <= ADDR_W'(RESET_PC);
    end else begin
      ce <= CHIP_ENABLE;
      // While the ROM was disabled the PC holds, so the first fetch is RESET_PC.
      if (ce == CHIP_ENABLE) begin
        if (flush)
          pc <= new_pc;
        else if (stall[STALL_PC] == STOP)
          pc <= pc;
        else if (branch_flag_i)
          pc <= branch_target_address_i;
        else
          pc <= pc + ADDR_W'(4);
      end
    end
  end

  assign fetched_inst = (ce == CHIP_ENABLE) ? inst_i : '0;

  if_stage_if_id #(
    .ADDR_W (ADDR_W),
    .INST_W (INST_W)
  ) u_if_id (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .stall_if (stall[STALL_IF_ID]),
    .stall_id (stall[STALL_ID_EX]),
    .if_pc    (pc),
    .if_inst  (fetched_inst),
    .id_pc    (id_pc),
    .id_inst  (id_inst)
  );

endmodule

// File: tb/tb_if_stage.sv
// Directed-vector bench for if_stage: each step pushes the hand-computed
// post-edge outputs into a scoreboard that a negedge monitor drains.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        branch_flag_i;
  logic [31:0] branch_target_address_i;
  logic [31:0] inst_i;
  logic [31:0] pc;
  logic        ce;
  logic [31:0] id_pc;
  logic [31:0] id_inst;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        ce;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
  } exp_t;

  exp_t exp_q[$];
  int   tests  = 0;
  int   failed = 0;

  if_stage dut (
    .clk                     (clk),
    .rst                     (rst),
    .stall                   (stall),
    .flush                   (flush),
    .new_pc                  (new_pc),
    .branch_flag_i           (branch_flag_i),
    .branch_target_address_i (branch_target_address_i),
    .inst_i                  (inst_i),
    .pc                      (pc),
    .ce                      (ce),
    .id_pc                   (id_pc),
    .id_inst                 (id_inst)
  );

  always #5 clk = ~clk;

  // Combinational ROM: address 0 holds ori, every other word encodes its address.
  always_comb begin
    inst_i = (pc == 32'h0) ? 32'h3401_1100 : (32'hA000_0000 | pc);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check({e.name, ".pc"},      pc,            e.pc);
      check({e.name, ".ce"},      {31'b0, ce},   {31'b0, e.ce});
      check({e.name, ".id_pc"},   id_pc,         e.id_pc);
      check({e.name, ".id_inst"}, id_inst,       e.id_inst);
    end
  end

  // Apply inputs for one edge, then record what the outputs must be after it.
  task automatic step(input string name, input logic r, input logic fl,
                      input logic [31:0] npc, input logic br, input logic [31:0] bt,
                      input logic [5:0] st, input logic [31:0] e_pc, input logic e_ce,
                      input logic [31:0] e_id_pc, input logic [31:0] e_id_inst);
    exp_t e;
    rst = r; flush = fl; new_pc = npc; branch_flag_i = br;
    branch_target_address_i = bt; stall = st;
    @(posedge clk);
    #1;
    e.name = name; e.pc = e_pc; e.ce = e_ce; e.id_pc = e_id_pc; e.id_inst = e_id_inst;
    exp_q.push_back(e);
  endtask

  task automatic run(input string name, input logic [31:0] e_pc,
                     input logic [31:0] e_id_pc, input logic [31:0] e_id_inst);
    step(name, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 6'b0, e_pc, 1'b1, e_id_pc, e_id_inst);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; new_pc = '0; branch_flag_i = 1'b0;
    branch_target_address_i = '0; stall = '0;

    // Reset held for the first 20 edges (~195 ns).
    for (int i = 0; i < 20; i++)
      step("reset", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 6'b0, 32'h0, 1'b0, 32'h0, 32'h0);

    step("release", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 6'b0, 32'h0, 1'b1, 32'h0, 32'h0);
    run("fetch4",  32'h4,  32'h0, 32'h3401_1100);
    run("fetch8",  32'h8,  32'h4, 32'hA000_0004);
    run("fetchC",  32'hC,  32'h8, 32'hA000_0008);
    run("fetch10", 32'h10, 32'hC, 32'hA000_000C);

    step("branch40", 1'b0, 1'b0, 32'h0, 1'b1, 32'h40, 6'b0, 32'h40, 1'b1, 32'h10, 32'hA000_0010);
    run("after_br", 32'h44, 32'h40, 32'hA000_0040);
    step("branch1C", 1'b0, 1'b0, 32'h0, 1'b1, 32'h1C, 6'b0, 32'h1C, 1'b1, 32'h44, 32'hA000_0044);
    run("fetch20", 32'h20, 32'h1C, 32'hA000_001C);

    step("load_use", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 6'b000111, 32'h20, 1'b1, 32'h1C, 32'hA000_001C);
    run("lu_release", 32'h24, 32'h20, 32'hA000_0020);
    run("fetch28",    32'h28, 32'h24, 32'hA000_0024);

    step("bubble", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 6'b000011, 32'h28, 1'b1, 32'h0, 32'h0);
    run("after_bubble", 32'h2C, 32'h28, 32'hA000_0028);

    step("br_vs_stall", 1'b0, 1'b0, 32'h0, 1'b1, 32'h80, 6'b000001, 32'h2C, 1'b1, 32'h2C, 32'hA000_002C);

    step("flush_all", 1'b0, 1'b1, 32'h180, 1'b1, 32'h40, 6'b000001, 32'h180, 1'b1, 32'h0, 32'h0);
    run("after_flush", 32'h184, 32'h180, 32'hA000_0180);

    step("flush_wrap", 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 6'b0, 32'hFFFF_FFFC, 1'b1, 32'h0, 32'h0);
    run("wrap",   32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    run("wrap4",  32'h4, 32'h0, 32'h3401_1100);
    run("wrap8",  32'h8, 32'h4, 32'hA000_0004);

    step("mid_reset", 1'b1, 1'b1, 32'h200, 1'b1, 32'h300, 6'b000111, 32'h0, 1'b0, 32'h0, 32'h0);
    step("re_release", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 6'b0, 32'h0, 1'b1, 32'h0, 32'h0);
    run("re_fetch4", 32'h4, 32'h0, 32'h3401_1100);
    run("re_fetch8", 32'h8, 32'h4, 32'hA000_0004);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++)
      @(negedge clk);
    #2;
    tests++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
